// File: rtl/limber_sram_ctrl_pkg.sv
// Shared definitions for the limber SRAM front-end.
// Holds the FSM state encoding, the latency counter width and the mask-width helper.
package limber_sram_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RMW_WAIT,
        S_RMW_WR,
        S_RSP
    } state_t;

    // Wide enough to count up to the largest supported RAM latency (4).
    localparam int DLY_CW = 3;

    function automatic int mask_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/limber_sram_ctrl_merge.sv
// Per-byte merge of new write data over the old RAM word.
// Ports: wdata/wmask (new data, byte enables), old (RAM word), merged (result).
module limber_sram_ctrl_merge #(
    parameter int DW = 32,
    parameter int MW = DW / 8
) (
    input  logic [DW-1:0] wdata,
    input  logic [MW-1:0] wmask,
    input  logic [DW-1:0] old,
    output logic [DW-1:0] merged
);

    always_comb begin
        merged = old;
        for (int b = 0; b < MW; b++) begin
            if (wmask[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
    end

endmodule

// File: rtl/limber_sram_ctrl.sv
// Command/response front-end for the single-port RAM; byte-masked writes run as read-modify-write.
// Ports: cmd_* (valid/ready command), rsp_* (valid/ready response), ram_* (RAM pins), clk, rst.
module limber_sram_ctrl
    import limber_sram_ctrl_pkg::*;
#(
    parameter int DP  = 64,
    parameter int DW  = 32,
    parameter int AW  = 6,
    parameter int DLY = 1,
    parameter int MW  = mask_w(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_read,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [MW-1:0] cmd_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [DLY_CW-1:0] CNT_LAST = DLY_CW'((DLY > 0) ? DLY - 1 : 0);

    state_t              state;
    logic [DLY_CW-1:0]   cnt;
    logic [AW-1:0]       lat_addr;
    logic [DW-1:0]       lat_wdata;
    logic [MW-1:0]       lat_wmask;
    logic [DW-1:0]       merged_q;
    logic [DW-1:0]       merged;
    logic [DW-1:0]       mrg_wdata;
    logic [MW-1:0]       mrg_wmask;
    logic                in_range;
    logic                full;
    logic                none;
    logic                accept;

    assign in_range = 32'(cmd_addr) < 32'(DP);
    assign full     = &cmd_wmask;
    assign none     = ~|cmd_wmask;
    // Gated by rst so the RAM pins and handshake drop the instant reset rises.
    assign cmd_ready = (state == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    // With DLY = 0 the merge happens in the accept cycle, before the latch.
    assign mrg_wdata = (state == S_IDLE) ? cmd_wdata : lat_wdata;
    assign mrg_wmask = (state == S_IDLE) ? cmd_wmask : lat_wmask;

    limber_sram_ctrl_merge #(.DW(DW), .MW(MW)) u_merge (
        .wdata  (mrg_wdata),
        .wmask  (mrg_wmask),
        .old    (ram_dout),
        .merged (merged)
    );

    always_comb begin
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = lat_addr;
        ram_din  = merged_q;
        if (state == S_IDLE) begin
            ram_addr = cmd_addr;
            ram_din  = cmd_wdata;
        end
        if (!rst) begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid && in_range && (cmd_read || !none)) begin
                        ram_cs = 1'b1;
                        ram_we = !cmd_read && full;
                    end
                end
                S_RMW_WR: begin
                    ram_cs = 1'b1;
                    ram_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            merged_q  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_addr  <= cmd_addr;
                        lat_wdata <= cmd_wdata;
                        lat_wmask <= cmd_wmask;
                        cnt       <= '0;
                        if (!in_range) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= S_RSP;
                        end else if (cmd_read) begin
                            if (DLY == 0) begin
                                rsp_err   <= 1'b0;
                                rsp_rdata <= ram_dout;
                                rsp_valid <= 1'b1;
                                state     <= S_RSP;
                            end else begin
                                state <= S_RD_WAIT;
                            end
                        end else if (full || none) begin
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= S_RSP;
                        end else if (DLY == 0) begin
                            merged_q <= merged;
                            state    <= S_RMW_WR;
                        end else begin
                            state <= S_RMW_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= ram_dout;
                        rsp_valid <= 1'b1;
                        state     <= S_RSP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RMW_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        merged_q <= merged;
                        state    <= S_RMW_WR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RMW_WR: begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                    state     <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_limber_sram_ctrl.sv
// Bench for limber_sram_ctrl: four instances at RAM latencies 1, 0, 2, 3, each on a behavioural RAM.
// Scoreboard of expected responses; directed steps in one initial block.
module tb_limber_sram_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
    } exp_t;

    function automatic int dly_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            2:       return 2;
            default: return 3;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid [4];
    logic        cmd_ready [4];
    logic        cmd_read  [4];
    logic [5:0]  cmd_addr  [4];
    logic [31:0] cmd_wdata [4];
    logic [3:0]  cmd_wmask [4];
    logic        rsp_valid [4];
    logic        rsp_ready [4];
    logic [31:0] rsp_rdata [4];
    logic        rsp_err   [4];
    logic        ram_cs    [4];
    logic        ram_we    [4];
    logic [5:0]  ram_addr  [4];
    logic [31:0] ram_din   [4];
    logic [31:0] ram_dout  [4];
    int          rd_cnt    [4];
    int          wr_cnt    [4];
    logic [31:0] model [4][64];
    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g
        localparam int D  = dly_of(k);
        localparam int PI = (D == 0) ? 1 : D;
        logic [31:0] mem  [64];
        logic [31:0] pipe [5];

        limber_sram_ctrl #(.DP(48), .DW(32), .AW(6), .DLY(D)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid[k]),
            .cmd_ready (cmd_ready[k]),
            .cmd_read  (cmd_read[k]),
            .cmd_addr  (cmd_addr[k]),
            .cmd_wdata (cmd_wdata[k]),
            .cmd_wmask (cmd_wmask[k]),
            .rsp_valid (rsp_valid[k]),
            .rsp_ready (rsp_ready[k]),
            .rsp_rdata (rsp_rdata[k]),
            .rsp_err   (rsp_err[k]),
            .ram_cs    (ram_cs[k]),
            .ram_we    (ram_we[k]),
            .ram_addr  (ram_addr[k]),
            .ram_din   (ram_din[k]),
            .ram_dout  (ram_dout[k])
        );

        initial begin
            for (int i = 0; i < 64; i++) mem[i] = '0;
            for (int i = 0; i < 5; i++) pipe[i] = '0;
            rd_cnt[k] = 0;
            wr_cnt[k] = 0;
        end

        always @(posedge clk) begin
            if (ram_cs[k] && ram_we[k]) begin
                mem[ram_addr[k]] <= ram_din[k];
                wr_cnt[k] <= wr_cnt[k] + 1;
            end
            if (ram_cs[k] && !ram_we[k]) begin
                pipe[1] <= mem[ram_addr[k]];
                rd_cnt[k] <= rd_cnt[k] + 1;
            end
            for (int i = 2; i < 5; i++) pipe[i] <= pipe[i-1];
        end

        assign ram_dout[k] = (D == 0) ? mem[ram_addr[k]] : pipe[PI];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input int k, input logic rd, input logic [5:0] a,
                       input logic [31:0] wd, input logic [3:0] m, input int hold);
        exp_t e;
        exp_t got;
        int   rd0;
        int   wr0;
        int   lat;
        int   n;
        int   d;
        d       = dly_of(k);
        e.err   = (a >= 6'd48);
        e.rdata = '0;
        e.lat   = 1;
        e.nrd   = 0;
        e.nwr   = 0;
        if (!e.err) begin
            if (rd) begin
                e.rdata = model[k][a];
                e.lat   = d + 1;
                e.nrd   = 1;
            end else if (m == 4'hF) begin
                model[k][a] = wd;
                e.nwr = 1;
            end else if (m != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) model[k][a][8*b +: 8] = wd[8*b +: 8];
                e.lat = d + 2;
                e.nrd = 1;
                e.nwr = 1;
            end
        end
        sb.push_back(e);

        @(negedge clk);
        rd0 = rd_cnt[k];
        wr0 = wr_cnt[k];
        cmd_valid[k] = 1'b1;
        cmd_read[k]  = rd;
        cmd_addr[k]  = a;
        cmd_wdata[k] = wd;
        cmd_wmask[k] = m;
        n = 0;
        while (!cmd_ready[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("k%0d accept", k), 32'(cmd_ready[k]), 32'd1);
        @(posedge clk);
        #1 cmd_valid[k] = 1'b0;
        lat = 1;
        while (!rsp_valid[k] && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        got = sb.pop_front();
        chk($sformatf("k%0d a%0d latency", k, a), 32'(lat), 32'(got.lat));
        chk($sformatf("k%0d a%0d rsp_valid", k, a), 32'(rsp_valid[k]), 32'd1);
        chk($sformatf("k%0d a%0d rdata", k, a), rsp_rdata[k], got.rdata);
        chk($sformatf("k%0d a%0d err", k, a), 32'(rsp_err[k]), 32'(got.err));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk($sformatf("k%0d hold%0d valid", k, h), 32'(rsp_valid[k]), 32'd1);
            chk($sformatf("k%0d hold%0d rdata", k, h), rsp_rdata[k], got.rdata);
            chk($sformatf("k%0d hold%0d cmd_ready", k, h), 32'(cmd_ready[k]), 32'd0);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[k] = 1'b0;
        chk($sformatf("k%0d a%0d ram reads", k, a), 32'(rd_cnt[k] - rd0), 32'(got.nrd));
        chk($sformatf("k%0d a%0d ram writes", k, a), 32'(wr_cnt[k] - wr0), 32'(got.nwr));
        chk($sformatf("k%0d a%0d idle again", k, a), 32'(cmd_ready[k]), 32'd1);
    endtask

    initial begin
        int wr0;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_read[k]  = 1'b0;
            cmd_addr[k]  = '0;
            cmd_wdata[k] = '0;
            cmd_wmask[k] = '0;
            rsp_ready[k] = 1'b0;
            for (int i = 0; i < 64; i++) model[k][i] = '0;
        end
        cmd_valid[0] = 1'b1;
        cmd_read[0]  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset ram_cs", 32'(ram_cs[0]), 32'd0);
        chk("reset ram_we", 32'(ram_we[0]), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset rsp_rdata", rsp_rdata[0], 32'd0);
        chk("reset rsp_err", 32'(rsp_err[0]), 32'd0);
        cmd_valid[0] = 1'b0;
        rst = 1'b0;
        #1 chk("reset cmd_ready", 32'(cmd_ready[0]), 32'd1);

        for (int k = 0; k < 4; k++) begin
            txn(k, 1'b0, 6'd5,  32'hDEADBEEF, 4'hF, 0);
            txn(k, 1'b1, 6'd5,  32'h0,        4'h0, 0);
            txn(k, 1'b0, 6'd5,  32'h11223344, 4'h5, 0);
            txn(k, 1'b1, 6'd5,  32'h0,        4'h0, 0);
            txn(k, 1'b0, 6'd5,  32'hFFFFFFFF, 4'h0, 0);
            txn(k, 1'b1, 6'd5,  32'h0,        4'h0, 0);
            txn(k, 1'b0, 6'd47, 32'hA5000000 + 32'(k), 4'hF, 0);
            txn(k, 1'b0, 6'd47, 32'h00C3C300, 4'hA, 0);
            txn(k, 1'b1, 6'd47, 32'h0,        4'h0, 0);
            txn(k, 1'b1, 6'd50, 32'h0,        4'h0, 0);
            txn(k, 1'b0, 6'd48, 32'h12345678, 4'hF, 0);
            txn(k, 1'b1, 6'd0,  32'h0,        4'h0, 0);
        end

        txn(0, 1'b1, 6'd5, 32'h0, 4'h0, 10);
        txn(2, 1'b1, 6'd47, 32'h0, 4'h0, 4);

        txn(3, 1'b0, 6'd9, 32'hAAAA5555, 4'hF, 0);
        @(negedge clk);
        wr0 = wr_cnt[3];
        cmd_valid[3] = 1'b1;
        cmd_read[3]  = 1'b0;
        cmd_addr[3]  = 6'd9;
        cmd_wdata[3] = 32'h01020304;
        cmd_wmask[3] = 4'h3;
        @(posedge clk);
        #1 cmd_valid[3] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rmw reset ram_cs", 32'(ram_cs[3]), 32'd0);
        chk("rmw reset ram_we", 32'(ram_we[3]), 32'd0);
        chk("rmw reset rsp_valid", 32'(rsp_valid[3]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rmw reset no write", 32'(wr_cnt[3] - wr0), 32'd0);
        chk("rmw reset stays idle", 32'(rsp_valid[3]), 32'd0);
        txn(3, 1'b1, 6'd9, 32'h0, 4'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
